// File: rtl/mdio_pkg.sv
// Shared Clause 22 MDIO definitions: FSM encoding, field codes, error codes and widths.
// Reused by the sta driver, the mmd responder and mdio_monitor.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_PRE   = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6
    } mdio_state_t;

    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OP   = 2'b01;
    localparam logic [1:0] ERR_TA   = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam int PHYADDR_W = 5;
    localparam int REGADDR_W = 5;
    localparam int DATA_W    = 16;
    localparam int HDR_W     = 2 + 2 + PHYADDR_W + REGADDR_W;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_WR) || (op == OP_RD);
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronisers for mdc, mdio_oe and the resolved line, plus a registered
// mdc rising-edge pulse. Line and oe get one extra stage so they stay aligned with mdc_rise.
module mdio_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    input  logic bus,
    input  logic oe,
    output logic bus_s,
    output logic oe_s,
    output logic mdc_rise
);

    logic [1:0] mdc_ff;
    logic [1:0] bus_ff;
    logic [1:0] oe_ff;
    logic       mdc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_ff   <= '0;
            bus_ff   <= '0;
            oe_ff    <= '0;
            mdc_d    <= 1'b0;
            mdc_rise <= 1'b0;
            bus_s    <= 1'b0;
            oe_s     <= 1'b0;
        end else begin
            mdc_ff   <= {mdc_ff[0], mdc};
            bus_ff   <= {bus_ff[0], bus};
            oe_ff    <= {oe_ff[0], oe};
            mdc_d    <= mdc_ff[1];
            mdc_rise <= mdc_ff[1] & ~mdc_d;
            bus_s    <= bus_ff[1];
            oe_s     <= oe_ff[1];
        end
    end

endmodule

// File: rtl/mdio_monitor.sv
// Passive Clause 22 MDIO frame decoder with one-cycle frame_vld / frame_err pulses.
// Define MDIO_MONITOR_STATS_EN to add saturating write/read/error frame counters.
//
// state   | meaning
// S_PRE   | counting consecutive preamble 1s, waiting for the ST 0
// S_ST    | first ST bit seen, expecting the second (1)
// S_OP    | collecting the 2 OP bits
// S_PHYAD | collecting 5 PHY address bits
// S_REGAD | collecting 5 register address bits
// S_TA    | checking the 2 turnaround bits against the OP direction
// S_DATA  | collecting 16 data bits, then report
module mdio_monitor
    import mdio_pkg::*;
#(
    parameter int PRE_LEN = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mdc,
    input  logic                 mdio_out,
    input  logic                 mdio_oe,
    input  logic                 mdio_in,
    output logic                 frame_vld,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [1:0]           ST,
    output logic [1:0]           OP,
    output logic [PHYADDR_W-1:0] PHYADDR,
    output logic [REGADDR_W-1:0] REGADDR,
    output logic [DATA_W-1:0]    DATA
`ifdef MDIO_MONITOR_STATS_EN
    ,
    output logic [15:0]          wr_cnt,
    output logic [15:0]          rd_cnt,
    output logic [15:0]          err_cnt
`endif
);

    localparam int PW = $clog2(PRE_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(PRE_LEN);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    mdio_state_t       state, state_nxt;
    logic [PW-1:0]     pre_cnt, pre_nxt;
    logic [TW-1:0]     tmo_cnt, tmo_nxt;
    logic [3:0]        bit_cnt, bit_nxt;
    logic [HDR_W-1:0]  hdr_sr, hdr_nxt, hdr_shift;
    logic [DATA_W-1:0] data_sr, data_nxt;
    logic              ta_err, ta_err_nxt;
    logic              vld_nxt, err_nxt, fld_ld;
    logic [1:0]        code_nxt;
    logic [1:0]        hdr_op;
    logic              bus, bus_s, oe_s, mdc_rise;

    assign bus = mdio_oe ? mdio_out : mdio_in;

    mdio_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .mdc      (mdc),
        .bus      (bus),
        .oe       (mdio_oe),
        .bus_s    (bus_s),
        .oe_s     (oe_s),
        .mdc_rise (mdc_rise)
    );

    // Header shifts in {ST, OP, PHYAD, REGAD} MSB first; OP lands at [11:10].
    assign hdr_shift = {hdr_sr[HDR_W-2:0], bus_s};
    assign hdr_op    = hdr_sr[HDR_W-3:HDR_W-4];

    always_comb begin
        state_nxt  = state;
        pre_nxt    = pre_cnt;
        bit_nxt    = bit_cnt;
        hdr_nxt    = hdr_sr;
        data_nxt   = data_sr;
        ta_err_nxt = ta_err;
        tmo_nxt    = (tmo_cnt != '0) ? tmo_cnt - 1'b1 : tmo_cnt;
        vld_nxt    = 1'b0;
        err_nxt    = 1'b0;
        fld_ld     = 1'b0;
        code_nxt   = err_code;

        if (mdc_rise) begin
            tmo_nxt = TMO_LOAD;
            unique case (state)
                S_PRE: begin
                    hdr_nxt = hdr_shift;
                    if (bus_s) begin
                        if (pre_cnt != PRE_MAX) pre_nxt = pre_cnt + 1'b1;
                    end else begin
                        pre_nxt = '0;
                        if (pre_cnt >= PRE_MAX) state_nxt = S_ST;
                    end
                end
                S_ST: begin
                    hdr_nxt = hdr_shift;
                    bit_nxt = '0;
                    state_nxt = bus_s ? S_OP : S_PRE;
                end
                S_OP: begin
                    hdr_nxt = hdr_shift;
                    if (bit_cnt == 4'd1) begin
                        bit_nxt = '0;
                        if (op_valid({hdr_sr[0], bus_s})) begin
                            state_nxt = S_PHYAD;
                        end else begin
                            err_nxt   = 1'b1;
                            code_nxt  = ERR_OP;
                            state_nxt = S_PRE;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
                S_PHYAD: begin
                    hdr_nxt = hdr_shift;
                    if (bit_cnt == 4'(PHYADDR_W - 1)) begin
                        bit_nxt   = '0;
                        state_nxt = S_REGAD;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
                S_REGAD: begin
                    hdr_nxt = hdr_shift;
                    if (bit_cnt == 4'(REGADDR_W - 1)) begin
                        bit_nxt    = '0;
                        ta_err_nxt = 1'b0;
                        state_nxt  = S_TA;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
                S_TA: begin
                    // Write: sta drives "10". Read: sta released, mmd drives 0 on the second bit.
                    if (hdr_op == OP_WR) begin
                        if (!oe_s || (bus_s != (bit_cnt == 4'd0))) ta_err_nxt = 1'b1;
                    end else begin
                        if (oe_s || ((bit_cnt == 4'd1) && bus_s)) ta_err_nxt = 1'b1;
                    end
                    if (bit_cnt == 4'd1) begin
                        bit_nxt   = '0;
                        state_nxt = S_DATA;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    data_nxt = {data_sr[DATA_W-2:0], bus_s};
                    if (bit_cnt == 4'(DATA_W - 1)) begin
                        bit_nxt   = '0;
                        pre_nxt   = '0;
                        fld_ld    = 1'b1;
                        state_nxt = S_PRE;
                        if (ta_err) begin
                            err_nxt  = 1'b1;
                            code_nxt = ERR_TA;
                        end else begin
                            vld_nxt  = 1'b1;
                            code_nxt = ERR_NONE;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
                default: state_nxt = S_PRE;
            endcase
        end else if ((state != S_PRE) && (tmo_cnt == '0)) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_TMO;
            pre_nxt   = '0;
            bit_nxt   = '0;
            state_nxt = S_PRE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PRE;
            pre_cnt   <= '0;
            tmo_cnt   <= '0;
            bit_cnt   <= '0;
            hdr_sr    <= '0;
            data_sr   <= '0;
            ta_err    <= 1'b0;
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            ST        <= '0;
            OP        <= '0;
            PHYADDR   <= '0;
            REGADDR   <= '0;
            DATA      <= '0;
        end else begin
            state     <= state_nxt;
            pre_cnt   <= pre_nxt;
            tmo_cnt   <= tmo_nxt;
            bit_cnt   <= bit_nxt;
            hdr_sr    <= hdr_nxt;
            data_sr   <= data_nxt;
            ta_err    <= ta_err_nxt;
            frame_vld <= vld_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
            if (fld_ld) begin
                ST      <= hdr_sr[HDR_W-1:HDR_W-2];
                OP      <= hdr_op;
                PHYADDR <= hdr_sr[PHYADDR_W+REGADDR_W-1:REGADDR_W];
                REGADDR <= hdr_sr[REGADDR_W-1:0];
                DATA    <= data_nxt;
            end
        end
    end

`ifdef MDIO_MONITOR_STATS_EN
    // Counters follow the pulse-cycle decision so they move together with frame_vld/frame_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (vld_nxt && (hdr_op == OP_WR) && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 1'b1;
            if (vld_nxt && (hdr_op == OP_RD) && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 1'b1;
            if (err_nxt && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mdio_monitor.sv
// Self-checking bench for mdio_monitor: directed vector table, random frames against a
// field-level outcome model, plus timeout and mid-frame reset sequences.
module tb_mdio_monitor;
    import mdio_pkg::*;

    localparam int PRE_LEN = 32;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst, mdc, mdio_out, mdio_oe, mdio_in;
    logic        frame_vld, frame_err;
    logic [1:0]  err_code, ST, OP;
    logic [4:0]  PHYADDR, REGADDR;
    logic [15:0] DATA;
`ifdef MDIO_MONITOR_STATS_EN
    logic [15:0] wr_cnt, rd_cnt, err_cnt;
`endif

    mdio_monitor #(.PRE_LEN(PRE_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .mdio_in   (mdio_in),
        .frame_vld (frame_vld),
        .frame_err (frame_err),
        .err_code  (err_code),
        .ST        (ST),
        .OP        (OP),
        .PHYADDR   (PHYADDR),
        .REGADDR   (REGADDR),
        .DATA      (DATA)
`ifdef MDIO_MONITOR_STATS_EN
        ,
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pre;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [1:0]  ta_oe;
        logic [1:0]  ta_val;
        logic [15:0] data;
        logic        ev_vld;
        logic        ev_err;
        logic [1:0]  code;
    } vec_t;

    typedef struct {
        logic        vld;
        logic        err;
        logic [1:0]  code;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] data;
        int          t;
    } ev_t;

    typedef struct {
        logic oe;
        logic val;
    } bit_t;

    int   cyc = 0;
    ev_t  ev_q[$];
    logic both_seen = 1'b0;
    bit_t bits[$];
    int   rises[$];
    int   ev_rd = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_wr = 0, exp_rd = 0, exp_er = 0;
    vec_t tbl[13];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (frame_vld || frame_err)) begin
            e.vld  = frame_vld;
            e.err  = frame_err;
            e.code = err_code;
            e.st   = ST;
            e.op   = OP;
            e.phy  = PHYADDR;
            e.rg   = REGADDR;
            e.data = DATA;
            e.t    = cyc;
            ev_q.push_back(e);
            if (frame_vld && frame_err) both_seen = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Outcome of one frame from the protocol rules, independent of how the decoder is built.
    function automatic vec_t model(input vec_t v);
        logic ta_ok;
        v.ev_vld = 1'b0;
        v.ev_err = 1'b0;
        v.code   = 2'b00;
        if (v.pre < PRE_LEN || v.st != 2'b01) return v;
        if (v.op != 2'b01 && v.op != 2'b10) begin
            v.ev_err = 1'b1;
            v.code   = 2'b01;
            return v;
        end
        if (v.op == 2'b01) ta_ok = (v.ta_oe == 2'b11) && (v.ta_val == 2'b10);
        else               ta_ok = (v.ta_oe == 2'b00) && (v.ta_val[0] == 1'b0);
        if (ta_ok) v.ev_vld = 1'b1;
        else begin
            v.ev_err = 1'b1;
            v.code   = 2'b10;
        end
        return v;
    endfunction

    task automatic build(input vec_t v);
        bit_t        b;
        logic [13:0] hdr;
        bits.delete();
        hdr = {v.st, v.op, v.phy, v.rg};
        for (int i = 0; i < v.pre; i++) begin
            b.oe = 1'b1; b.val = 1'b1; bits.push_back(b);
        end
        for (int i = 13; i >= 0; i--) begin
            b.oe = 1'b1; b.val = hdr[i]; bits.push_back(b);
        end
        for (int i = 1; i >= 0; i--) begin
            b.oe = v.ta_oe[i]; b.val = v.ta_val[i]; bits.push_back(b);
        end
        for (int i = 15; i >= 0; i--) begin
            b.oe = (v.op != 2'b10); b.val = v.data[i]; bits.push_back(b);
        end
    endtask

    task automatic drive_bit(input logic oe, input logic val);
        @(negedge clk);
        mdio_oe = oe;
        if (oe) begin
            mdio_out = val;
            mdio_in  = 1'($urandom);
        end else begin
            mdio_in  = val;
            mdio_out = 1'($urandom);
        end
        repeat (3) @(negedge clk);
        mdc = 1'b1;
        rises.push_back(cyc);
        repeat (4) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send(input vec_t v, input int nbits);
        build(v);
        rises.delete();
        for (int i = 0; i < nbits && i < bits.size(); i++) drive_bit(bits[i].oe, bits[i].val);
        mdio_oe  = 1'b1;
        mdio_out = 1'b1;
    endtask

    task automatic check_frame(input vec_t v, input int id);
        int  n;
        int  t_exp;
        ev_t e;
        repeat (12) @(negedge clk);
        n = ev_q.size() - ev_rd;
        chk($sformatf("v%0d_events", id), 32'(n), 32'((v.ev_vld || v.ev_err) ? 1 : 0));
        if (n > 0) begin
            e = ev_q[ev_rd];
            chk($sformatf("v%0d_vld", id), 32'(e.vld), 32'(v.ev_vld));
            chk($sformatf("v%0d_err", id), 32'(e.err), 32'(v.ev_err));
            chk($sformatf("v%0d_code", id), 32'(e.code), 32'(v.code));
            if (v.ev_err && v.code == 2'b01) t_exp = rises[v.pre + 3] + 4;
            else                             t_exp = rises[rises.size() - 1] + 4;
            chk($sformatf("v%0d_latency", id), 32'(e.t), 32'(t_exp));
            if (v.ev_vld) begin
                chk($sformatf("v%0d_st", id), 32'(e.st), 32'(v.st));
                chk($sformatf("v%0d_op", id), 32'(e.op), 32'(v.op));
                chk($sformatf("v%0d_phy", id), 32'(e.phy), 32'(v.phy));
                chk($sformatf("v%0d_reg", id), 32'(e.rg), 32'(v.rg));
                chk($sformatf("v%0d_data", id), 32'(e.data), 32'(v.data));
                chk($sformatf("v%0d_data_held", id), 32'(DATA), 32'(v.data));
            end
            if (v.ev_vld || v.ev_err)
                chk($sformatf("v%0d_code_held", id), 32'(err_code), 32'(v.code));
        end
        ev_rd = ev_q.size();
        if (v.ev_vld && v.op == 2'b01) exp_wr++;
        if (v.ev_vld && v.op == 2'b10) exp_rd++;
        if (v.ev_err) exp_er++;
    endtask

    initial begin
        vec_t v;
        int   kind;
        int   n;
        int   last;
        ev_t  e;

        //           pre st     op     phy    reg    ta_oe  ta_val data      vld err code
        tbl[0]  = '{32, 2'b01, 2'b01, 5'h0E, 5'h0D, 2'b11, 2'b10, 16'h3f7f, 1'b1, 1'b0, 2'b00};
        tbl[1]  = '{32, 2'b01, 2'b10, 5'h0E, 5'h0D, 2'b00, 2'b10, 16'h4534, 1'b1, 1'b0, 2'b00};
        tbl[2]  = '{20, 2'b01, 2'b01, 5'h0E, 5'h0D, 2'b11, 2'b10, 16'h3f7e, 1'b0, 1'b0, 2'b00};
        tbl[3]  = '{32, 2'b01, 2'b01, 5'h0E, 5'h0D, 2'b11, 2'b10, 16'h3f7f, 1'b1, 1'b0, 2'b00};
        tbl[4]  = '{32, 2'b01, 2'b00, 5'h0E, 5'h0D, 2'b11, 2'b10, 16'h1234, 1'b0, 1'b1, 2'b01};
        tbl[5]  = '{33, 2'b01, 2'b10, 5'h1F, 5'h00, 2'b00, 2'b00, 16'hffff, 1'b1, 1'b0, 2'b00};
        tbl[6]  = '{32, 2'b01, 2'b11, 5'h01, 5'h02, 2'b11, 2'b10, 16'h0000, 1'b0, 1'b1, 2'b01};
        tbl[7]  = '{32, 2'b00, 2'b01, 5'h03, 5'h04, 2'b11, 2'b10, 16'h8000, 1'b0, 1'b0, 2'b00};
        tbl[8]  = '{32, 2'b01, 2'b01, 5'h05, 5'h06, 2'b11, 2'b11, 16'hA5A4, 1'b0, 1'b1, 2'b10};
        tbl[9]  = '{32, 2'b01, 2'b10, 5'h07, 5'h08, 2'b10, 2'b10, 16'h5A5A, 1'b0, 1'b1, 2'b10};
        tbl[10] = '{32, 2'b01, 2'b01, 5'h09, 5'h0A, 2'b10, 2'b10, 16'hC3C2, 1'b0, 1'b1, 2'b10};
        tbl[11] = '{31, 2'b01, 2'b01, 5'h1F, 5'h1F, 2'b11, 2'b10, 16'hFFFE, 1'b0, 1'b0, 2'b00};
        tbl[12] = '{32, 2'b01, 2'b01, 5'h00, 5'h00, 2'b11, 2'b10, 16'h0000, 1'b1, 1'b0, 2'b00};

        rst = 1'b1; mdc = 1'b0; mdio_oe = 1'b1; mdio_out = 1'b1; mdio_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_flags", 32'({frame_vld, frame_err, err_code}), 32'd0);
        chk("reset_fields", 32'({ST, OP, PHYADDR, REGADDR, DATA}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            send(tbl[i], 1000);
            check_frame(tbl[i], i);
        end

        // Random frames; non-decoding kinds end in 0 so no preamble 1s carry into the next frame.
        for (int i = 0; i < 30; i++) begin
            kind     = $urandom_range(0, 6);
            v.pre    = (kind == 4) ? $urandom_range(1, PRE_LEN - 1) : $urandom_range(PRE_LEN, PRE_LEN + 8);
            v.st     = (kind == 5) ? 2'b00 : 2'b01;
            v.op     = (kind == 3) ? (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11)
                                   : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
            v.phy    = 5'($urandom);
            v.rg     = 5'($urandom);
            v.data   = 16'($urandom);
            v.ta_oe  = (v.op == 2'b10) ? 2'b00 : 2'b11;
            v.ta_val = (v.op == 2'b10) ? {1'($urandom), 1'b0} : 2'b10;
            if (kind == 6) begin
                v.ta_oe  = 2'($urandom);
                v.ta_val = 2'($urandom);
            end
            if (kind >= 3 && kind <= 5) v.data[0] = 1'b0;
            v = model(v);
            send(v, 1000);
            check_frame(v, 100 + i);
        end

        // mdc stops after REGADDR: timeout abort, then a normal frame must decode.
        send(tbl[0], PRE_LEN + 14);
        last = rises[rises.size() - 1];
        repeat (100) @(negedge clk);
        n = ev_q.size() - ev_rd;
        chk("tmo_events", 32'(n), 32'd1);
        if (n > 0) begin
            e = ev_q[ev_rd];
            chk("tmo_err", 32'({e.vld, e.err}), 32'b01);
            chk("tmo_code", 32'(e.code), 32'b11);
            chk("tmo_time", 32'(e.t), 32'(last + TIMEOUT + 4));
        end
        ev_rd = ev_q.size();
        exp_er++;
        send(tbl[0], 1000);
        check_frame(tbl[0], 200);

        // Reset in the middle of DATA: no pulse, outputs cleared, then a clean frame.
        send(tbl[1], PRE_LEN + 14 + 2 + 8);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_er = 0;
        repeat (12) @(negedge clk);
        chk("rst_mid_events", 32'(ev_q.size() - ev_rd), 32'd0);
        chk("rst_mid_flags", 32'({frame_vld, frame_err, err_code}), 32'd0);
        chk("rst_mid_fields", 32'({ST, OP, PHYADDR, REGADDR, DATA}), 32'd0);
        ev_rd = ev_q.size();
        send(tbl[1], 1000);
        check_frame(tbl[1], 201);
        send(tbl[4], 1000);
        check_frame(tbl[4], 202);

        chk("vld_err_exclusive", 32'(both_seen), 32'd0);
`ifdef MDIO_MONITOR_STATS_EN
        chk("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        chk("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
        chk("err_cnt", 32'(err_cnt), 32'(exp_er));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
